// File: rtl/gb_if_seq.sv
// Single-transfer sequencer between the global buffer and the chip IF block.
// Accepts one request, runs the IF config handshake, then passes `len` words through.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | ready for a client request
//   CFG    | presenting {id, rw} to the IF until it accepts the config
//   WR     | passing GB source words through to the IF write port
//   RD     | passing IF read words through to the GB sink port
//   DONE   | one-cycle completion pulse, then back to IDLE
module gb_if_seq #(
    parameter int PORT_WIDTH = 128,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_val,
    output logic                  req_rdy,
    input  logic                  req_rw,
    input  logic [2:0]            req_id,
    input  logic [LEN_WIDTH-1:0]  req_len,

    input  logic                  src_val,
    output logic                  src_rdy,
    input  logic [PORT_WIDTH-1:0] src_data,

    output logic                  snk_val,
    input  logic                  snk_rdy,
    output logic [PORT_WIDTH-1:0] snk_data,

    output logic                  GBIF_cfg_val,
    input  logic                  IFGB_cfg_rdy,
    output logic [3:0]            GBIF_cfg_info,

    output logic                  GBIF_wr_val,
    input  logic                  IFGB_wr_rdy,
    output logic [PORT_WIDTH-1:0] GBIF_wr_data,

    input  logic                  IFGB_rd_val,
    output logic                  GBIF_rd_rdy,
    input  logic [PORT_WIDTH-1:0] IFGB_rd_data,

    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  beat_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_WR,
        S_RD,
        S_DONE
    } state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   beat_q;
    logic [3:0]             cfg_info_q;
    logic                   req_rdy_q;
    logic                   busy_q;
    logic                   cfg_val_q;
    logic                   wr_en_q;
    logic                   rd_en_q;
    logic                   done_q;

    logic                   wr_beat;
    logic                   rd_beat;
    logic                   last_beat;

    // Data paths are pure pass-through; only the handshake strobes are gated by state.
    assign GBIF_wr_val  = wr_en_q & src_val;
    assign src_rdy      = wr_en_q & IFGB_wr_rdy;
    assign GBIF_wr_data = src_data;

    assign snk_val      = rd_en_q & IFGB_rd_val;
    assign GBIF_rd_rdy  = rd_en_q & snk_rdy;
    assign snk_data     = IFGB_rd_data;

    assign wr_beat      = wr_en_q & src_val & IFGB_wr_rdy;
    assign rd_beat      = rd_en_q & IFGB_rd_val & snk_rdy;
    assign last_beat    = (beat_q == (len_q - LEN_WIDTH'(1)));

    assign req_rdy       = req_rdy_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign beat_cnt      = beat_q;
    assign GBIF_cfg_val  = cfg_val_q;
    assign GBIF_cfg_info = cfg_info_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            len_q      <= '0;
            beat_q     <= '0;
            cfg_info_q <= '0;
            req_rdy_q  <= 1'b1;
            busy_q     <= 1'b0;
            cfg_val_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_val) begin
                        state      <= S_CFG;
                        len_q      <= req_len;
                        beat_q     <= '0;
                        cfg_info_q <= {req_id, req_rw};
                        req_rdy_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        cfg_val_q  <= 1'b1;
                    end
                end

                S_CFG: begin
                    if (IFGB_cfg_rdy) begin
                        cfg_val_q <= 1'b0;
                        if (len_q == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else if (cfg_info_q[0]) begin
                            state   <= S_RD;
                            rd_en_q <= 1'b1;
                        end else begin
                            state   <= S_WR;
                            wr_en_q <= 1'b1;
                        end
                    end
                end

                S_WR: begin
                    if (wr_beat) begin
                        beat_q <= beat_q + LEN_WIDTH'(1);
                        if (last_beat) begin
                            state   <= S_DONE;
                            wr_en_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                S_RD: begin
                    if (rd_beat) begin
                        beat_q <= beat_q + LEN_WIDTH'(1);
                        if (last_beat) begin
                            state   <= S_DONE;
                            rd_en_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state     <= S_IDLE;
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    req_rdy_q <= 1'b1;
                end

                default: begin
                    state     <= S_IDLE;
                    cfg_val_q <= 1'b0;
                    wr_en_q   <= 1'b0;
                    rd_en_q   <= 1'b0;
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    req_rdy_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gb_if_seq.sv
// Self-checking bench for gb_if_seq: directed scenarios plus randomized stalls,
// checked against an observation-based transfer model (words in == words out, timing rules).
module tb_gb_if_seq;

    localparam int PW = 128;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_val, req_rdy, req_rw;
    logic [2:0]    req_id;
    logic [LW-1:0] req_len;
    logic          src_val, src_rdy;
    logic [PW-1:0] src_data;
    logic          snk_val, snk_rdy;
    logic [PW-1:0] snk_data;
    logic          GBIF_cfg_val, IFGB_cfg_rdy;
    logic [3:0]    GBIF_cfg_info;
    logic          GBIF_wr_val, IFGB_wr_rdy;
    logic [PW-1:0] GBIF_wr_data;
    logic          IFGB_rd_val, GBIF_rd_rdy;
    logic [PW-1:0] IFGB_rd_data;
    logic          busy, done;
    logic [LW-1:0] beat_cnt;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    gb_if_seq #(.PORT_WIDTH(PW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_rw(req_rw), .req_id(req_id), .req_len(req_len),
        .src_val(src_val), .src_rdy(src_rdy), .src_data(src_data),
        .snk_val(snk_val), .snk_rdy(snk_rdy), .snk_data(snk_data),
        .GBIF_cfg_val(GBIF_cfg_val), .IFGB_cfg_rdy(IFGB_cfg_rdy), .GBIF_cfg_info(GBIF_cfg_info),
        .GBIF_wr_val(GBIF_wr_val), .IFGB_wr_rdy(IFGB_wr_rdy), .GBIF_wr_data(GBIF_wr_data),
        .IFGB_rd_val(IFGB_rd_val), .GBIF_rd_rdy(GBIF_rd_rdy), .IFGB_rd_data(IFGB_rd_data),
        .busy(busy), .done(done), .beat_cnt(beat_cnt)
    );

    // Observations gathered by run_xfer for the calling test to judge.
    int            r_acc, r_cfg_hs, r_last, r_done, r_cfg_cycles, r_beats, r_done_cnt;
    logic [3:0]    r_info;
    bit            r_info_chg, r_bad, r_timeout;
    logic [LW-1:0] r_bc_done;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] obs_q[$];

    function automatic logic [PW-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_val = 1'b0; req_rw = 1'b0; req_id = '0; req_len = '0;
        src_val = 1'b0; src_data = '0; snk_rdy = 1'b0;
        IFGB_cfg_rdy = 1'b0; IFGB_wr_rdy = 1'b0; IFGB_rd_val = 1'b0; IFGB_rd_data = '0;
    endtask

    // Drives one request and both data sides, recording every handshake seen.
    // mode 0: no stalls; mode 1: snk_rdy toggles 1,0,1,... from the first data cycle; mode 2: random stalls of pct%.
    task automatic run_xfer(input logic rw, input logic [2:0] id, input logic [LW-1:0] len,
                            input int cfg_stall, input int mode, input int pct);
        logic [PW-1:0] src_w, if_w;
        bit acc, cfg_ok, fin, src_take, if_take;
        int budget;
        r_acc = -1; r_cfg_hs = -1; r_last = -1; r_done = -1;
        r_cfg_cycles = 0; r_beats = 0; r_done_cnt = 0;
        r_info = '0; r_info_chg = 0; r_bad = 0; r_timeout = 0; r_bc_done = '0;
        exp_q.delete(); obs_q.delete();
        src_w = rnd_word(); if_w = rnd_word();
        acc = 0; cfg_ok = 0; fin = 0;
        budget = int'(len) * 8 + cfg_stall + 100;
        req_val = 1'b1; req_rw = rw; req_id = id; req_len = len;
        for (int k = 0; k < budget && !fin; k++) begin
            IFGB_cfg_rdy = (r_cfg_cycles >= cfg_stall);
            if (mode == 2) begin
                src_val     = ($urandom_range(99) >= pct);
                IFGB_wr_rdy = ($urandom_range(99) >= pct);
                IFGB_rd_val = ($urandom_range(99) >= pct);
                snk_rdy     = ($urandom_range(99) >= pct);
            end else begin
                src_val     = 1'b1;
                IFGB_wr_rdy = 1'b1;
                IFGB_rd_val = 1'b1;
                snk_rdy     = (mode == 1 && cfg_ok) ? (((cyc - r_cfg_hs - 1) % 2) == 0) : 1'b1;
            end
            src_data = src_w;
            IFGB_rd_data = if_w;
            #1;
            src_take = 0; if_take = 0;
            if (req_val && req_rdy) begin r_acc = cyc; acc = 1; end
            if (GBIF_cfg_val) begin
                r_cfg_cycles++;
                if (r_cfg_cycles == 1) r_info = GBIF_cfg_info;
                else if (GBIF_cfg_info !== r_info) r_info_chg = 1;
                if (IFGB_cfg_rdy) begin r_cfg_hs = cyc; cfg_ok = 1; end
            end
            if ((rw || len == 0) && (GBIF_wr_val || src_rdy)) r_bad = 1;
            if ((!rw || len == 0) && (snk_val || GBIF_rd_rdy)) r_bad = 1;
            if (src_val && src_rdy) begin exp_q.push_back(src_w); src_take = 1; end
            if (GBIF_wr_val && IFGB_wr_rdy) begin obs_q.push_back(GBIF_wr_data); r_beats++; r_last = cyc; end
            if (IFGB_rd_val && GBIF_rd_rdy) begin exp_q.push_back(if_w); if_take = 1; end
            if (snk_val && snk_rdy) begin obs_q.push_back(snk_data); r_beats++; r_last = cyc; end
            if (done) begin r_done_cnt++; r_done = cyc; r_bc_done = beat_cnt; fin = 1; end
            tick();
            if (acc) req_val = 1'b0;
            if (src_take) src_w = rnd_word();
            if (if_take) if_w = rnd_word();
        end
        if (!fin) r_timeout = 1;
        req_val = 1'b0; src_val = 1'b0; IFGB_wr_rdy = 1'b0; IFGB_rd_val = 1'b0; snk_rdy = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) tick();
        n_tests++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_req_rdy got %0b want 1", req_rdy); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_tests++; if (beat_cnt !== '0) begin n_fail++; $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
        n_tests++; if (GBIF_cfg_info !== 4'h0) begin n_fail++; $display("FAIL reset_cfg_info got %h want 0", GBIF_cfg_info); end
        n_tests++;
        if ({GBIF_cfg_val, GBIF_wr_val, src_rdy, snk_val, GBIF_rd_rdy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_strobes got %b want 00000", {GBIF_cfg_val, GBIF_wr_val, src_rdy, snk_val, GBIF_rd_rdy});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_burst();
        int bad_i;
        run_xfer(1'b0, 3'd5, 12'd4, 0, 0, 0);
        n_tests++; if (r_timeout) begin n_fail++; $display("FAIL wr_timeout got no done want done"); end
        n_tests++; if (r_info !== 4'b1010) begin n_fail++; $display("FAIL wr_cfg_info got %b want 1010", r_info); end
        n_tests++; if (r_cfg_cycles != 1) begin n_fail++; $display("FAIL wr_cfg_cycles got %0d want 1", r_cfg_cycles); end
        n_tests++; if (r_cfg_hs != r_acc + 1) begin n_fail++; $display("FAIL wr_cfg_latency got %0d want %0d", r_cfg_hs - r_acc, 1); end
        bad_i = (obs_q.size() == 4 && exp_q.size() == 4) ? -1 : 99;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i] && bad_i < 0) bad_i = i;
        n_tests++; if (bad_i != -1) begin n_fail++; $display("FAIL wr_data got %0d words (bad idx %0d) want 4 matching", obs_q.size(), bad_i); end
        n_tests++; if (r_done != r_acc + 6) begin n_fail++; $display("FAIL wr_done_time got t+%0d want t+6", r_done - r_acc); end
        n_tests++; if (r_bc_done !== 12'd4) begin n_fail++; $display("FAIL wr_beat_cnt got %0d want 4", r_bc_done); end
        n_tests++; if (r_bad) begin n_fail++; $display("FAIL wr_read_strobes got 1 want 0"); end
        n_tests++; if (req_rdy !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle_after got rdy=%0b busy=%0b want 1 0", req_rdy, busy); end
        n_tests++; if (beat_cnt !== 12'd4) begin n_fail++; $display("FAIL wr_beat_cnt_hold got %0d want 4", beat_cnt); end
    endtask

    task automatic test_read_backpressure();
        int bad_i;
        run_xfer(1'b1, 3'd2, 12'd3, 0, 1, 0);
        n_tests++; if (r_timeout) begin n_fail++; $display("FAIL rd_timeout got no done want done"); end
        n_tests++; if (r_info !== 4'b0101) begin n_fail++; $display("FAIL rd_cfg_info got %b want 0101", r_info); end
        bad_i = (obs_q.size() == 3 && exp_q.size() == 3) ? -1 : 99;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i] && bad_i < 0) bad_i = i;
        n_tests++; if (bad_i != -1) begin n_fail++; $display("FAIL rd_data got %0d words (bad idx %0d) want 3 matching", obs_q.size(), bad_i); end
        n_tests++; if (r_done != r_last + 1) begin n_fail++; $display("FAIL rd_done_after_last got %0d want %0d", r_done, r_last + 1); end
        n_tests++; if (r_done != r_acc + 7) begin n_fail++; $display("FAIL rd_done_time got t+%0d want t+7", r_done - r_acc); end
        n_tests++; if (r_bc_done !== 12'd3) begin n_fail++; $display("FAIL rd_beat_cnt got %0d want 3", r_bc_done); end
        n_tests++; if (r_bad) begin n_fail++; $display("FAIL rd_write_strobes got 1 want 0"); end
    endtask

    task automatic test_cfg_stall_len0();
        run_xfer(1'b0, 3'd6, 12'd0, 5, 0, 0);
        n_tests++; if (r_timeout) begin n_fail++; $display("FAIL cfg0_timeout got no done want done"); end
        n_tests++; if (r_cfg_cycles != 6) begin n_fail++; $display("FAIL cfg0_cfg_cycles got %0d want 6", r_cfg_cycles); end
        n_tests++; if (r_info_chg || r_info !== 4'b1100) begin n_fail++; $display("FAIL cfg0_info got %b chg=%0b want 1100 stable", r_info, r_info_chg); end
        n_tests++; if (r_done != r_cfg_hs + 1) begin n_fail++; $display("FAIL cfg0_done_time got %0d want %0d", r_done, r_cfg_hs + 1); end
        n_tests++; if (r_bad || r_beats != 0) begin n_fail++; $display("FAIL cfg0_data_strobes got bad=%0b beats=%0d want 0 0", r_bad, r_beats); end
        n_tests++; if (r_bc_done !== 12'd0) begin n_fail++; $display("FAIL cfg0_beat_cnt got %0d want 0", r_bc_done); end
    endtask

    task automatic test_reset_mid_burst();
        int beats = 0;
        bit acc = 0, seen_done = 0;
        idle_inputs();
        req_val = 1'b1; req_rw = 1'b0; req_id = 3'd3; req_len = 12'd8;
        IFGB_cfg_rdy = 1'b1; src_val = 1'b1; IFGB_wr_rdy = 1'b1;
        for (int k = 0; k < 40 && beats < 3; k++) begin
            src_data = rnd_word();
            #1;
            if (req_val && req_rdy) acc = 1;
            if (GBIF_wr_val && IFGB_wr_rdy) beats++;
            if (done) seen_done = 1;
            tick();
            if (acc) req_val = 1'b0;
        end
        n_tests++; if (beats != 3) begin n_fail++; $display("FAIL rst_mid_beats got %0d want 3", beats); end
        n_tests++; if (beat_cnt !== 12'd3) begin n_fail++; $display("FAIL rst_mid_cnt_before got %0d want 3", beat_cnt); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || req_rdy !== 1'b1 || beat_cnt !== '0 || GBIF_wr_val !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_idle got busy=%0b rdy=%0b cnt=%0d wr_val=%0b want 0 1 0 0", busy, req_rdy, beat_cnt, GBIF_wr_val);
        end
        for (int k = 0; k < 5; k++) begin
            if (done || busy) seen_done = 1;
            tick();
        end
        n_tests++; if (seen_done) begin n_fail++; $display("FAIL rst_mid_no_done got activity want none"); end
        idle_inputs();
        run_xfer(1'b0, 3'd1, 12'd2, 0, 0, 0);
        n_tests++;
        if (r_timeout || r_beats != 2 || r_done != r_acc + 4 || obs_q.size() != 2 || obs_q != exp_q) begin
            n_fail++; $display("FAIL rst_mid_followup got beats=%0d done=t+%0d want 2 t+4", r_beats, r_done - r_acc);
        end
    endtask

    task automatic test_back_to_back();
        int acc_c[4];
        int dn_c[4];
        int n_acc = 0, n_dn = 0;
        for (int i = 0; i < 4; i++) begin acc_c[i] = -1; dn_c[i] = -1; end
        idle_inputs();
        req_val = 1'b1; req_rw = 1'b0; req_id = 3'd1; req_len = 12'd1;
        IFGB_cfg_rdy = 1'b1; src_val = 1'b1; IFGB_wr_rdy = 1'b1;
        for (int k = 0; k < 30; k++) begin
            src_data = rnd_word();
            #1;
            if (req_val && req_rdy) begin if (n_acc < 4) acc_c[n_acc] = cyc; n_acc++; end
            if (done) begin if (n_dn < 4) dn_c[n_dn] = cyc; n_dn++; end
            tick();
            if (n_acc >= 2) req_val = 1'b0;
        end
        idle_inputs();
        n_tests++; if (n_acc != 2) begin n_fail++; $display("FAIL b2b_accepts got %0d want 2", n_acc); end
        n_tests++; if (n_dn != 2) begin n_fail++; $display("FAIL b2b_dones got %0d want 2", n_dn); end
        n_tests++; if (dn_c[0] != acc_c[0] + 3) begin n_fail++; $display("FAIL b2b_first_done got t+%0d want t+3", dn_c[0] - acc_c[0]); end
        n_tests++; if (acc_c[1] != dn_c[0] + 1) begin n_fail++; $display("FAIL b2b_second_accept got %0d want %0d", acc_c[1], dn_c[0] + 1); end
        n_tests++; if (dn_c[1] != acc_c[1] + 3) begin n_fail++; $display("FAIL b2b_second_done got t+%0d want t+3", dn_c[1] - acc_c[1]); end
    endtask

    task automatic test_max_len();
        int bad_i;
        run_xfer(1'b1, 3'd7, 12'd4095, 0, 0, 0);
        n_tests++; if (r_timeout) begin n_fail++; $display("FAIL max_timeout got no done want done"); end
        n_tests++; if (r_bc_done !== 12'd4095) begin n_fail++; $display("FAIL max_beat_cnt got %0d want 4095", r_bc_done); end
        n_tests++; if (r_done != r_acc + 4097) begin n_fail++; $display("FAIL max_done_time got t+%0d want t+4097", r_done - r_acc); end
        bad_i = (obs_q.size() == 4095 && exp_q.size() == 4095) ? -1 : 99;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i] && bad_i < 0) bad_i = i;
        n_tests++; if (bad_i != -1) begin n_fail++; $display("FAIL max_data got %0d words (bad idx %0d) want 4095 matching", obs_q.size(), bad_i); end
    endtask

    task automatic test_random();
        logic          rw;
        logic [2:0]    id;
        logic [LW-1:0] len;
        int            stall, bad_i, want_done;
        for (int t = 0; t < 12; t++) begin
            rw = 1'($urandom_range(1));
            id = 3'($urandom_range(7));
            len = LW'($urandom_range(12));
            stall = $urandom_range(3);
            run_xfer(rw, id, len, stall, 2, 30);
            n_tests++; if (r_timeout) begin n_fail++; $display("FAIL rnd%0d_timeout got no done want done", t); end
            n_tests++; if (r_info_chg || r_info !== {id, rw}) begin n_fail++; $display("FAIL rnd%0d_info got %b want %b", t, r_info, {id, rw}); end
            n_tests++; if (r_cfg_hs != r_acc + 1 + stall) begin n_fail++; $display("FAIL rnd%0d_cfg_time got t+%0d want t+%0d", t, r_cfg_hs - r_acc, 1 + stall); end
            bad_i = (obs_q.size() == int'(len) && exp_q.size() == int'(len)) ? -1 : 99;
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i] && bad_i < 0) bad_i = i;
            n_tests++; if (bad_i != -1) begin n_fail++; $display("FAIL rnd%0d_data got %0d words (bad idx %0d) want %0d matching", t, obs_q.size(), bad_i, len); end
            want_done = (len == 0) ? r_cfg_hs + 1 : r_last + 1;
            n_tests++; if (r_done != want_done) begin n_fail++; $display("FAIL rnd%0d_done_time got %0d want %0d", t, r_done, want_done); end
            n_tests++; if (r_bc_done !== len) begin n_fail++; $display("FAIL rnd%0d_beat_cnt got %0d want %0d", t, r_bc_done, len); end
            n_tests++; if (r_bad) begin n_fail++; $display("FAIL rnd%0d_strobes got wrong-side strobe want none", t); end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_write_burst();
        test_read_backpressure();
        test_cfg_stall_len0();
        test_reset_mid_burst();
        test_back_to_back();
        test_max_len();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gb_if_seq.md
# gb_if_seq

Transfer sequencer between the global buffer (GB) and the chip IF block. A GB client posts one request (direction, 3-bit id, word count). The block then issues the IF config handshake carrying `{id, rw}` and streams exactly that many 128-bit words: GB→IF for writes, IF→GB for reads. It ends each request with a one-cycle done pulse. At most one transfer is in flight at a time.

## Interface
Parameters:
- PORT_WIDTH, 128, data word width on both sides
- LEN_WIDTH, 12, width of the word-count field

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_val  in  1  client request valid
- req_rdy  out  1  request accepted when req_val && req_rdy
- req_rw  in  1  1 = read (IF→GB), 0 = write (GB→IF)
- req_id  in  3  transfer id forwarded to IF
- req_len  in  LEN_WIDTH  number of data words; 0 = config only
- src_val  in  1  GB write-data valid
- src_rdy  out  1  GB write-data ready
- src_data  in  PORT_WIDTH  GB write data
- snk_val  out  1  read data valid to GB
- snk_rdy  in  1  GB read-data ready
- snk_data  out  PORT_WIDTH  read data to GB
- GBIF_cfg_val  out  1  config valid to IF
- IFGB_cfg_rdy  in  1  IF config ready
- GBIF_cfg_info  out  4  {id[2:0], rw}; bit0 = rw
- GBIF_wr_val  out  1  write valid to IF
- IFGB_wr_rdy  in  1  IF write ready
- GBIF_wr_data  out  PORT_WIDTH  write data to IF
- IFGB_rd_val  in  1  IF read valid
- GBIF_rd_rdy  out  1  read ready to IF
- IFGB_rd_data  in  PORT_WIDTH  IF read data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a request completes
- beat_cnt  out  LEN_WIDTH  words transferred in the current or last request

## Operation
- FSM states: IDLE, CFG, WR, RD, DONE. All transitions are registered.
- IDLE:
  - req_rdy = 1.
  - On req_val, latch rw, id and len; clear beat_cnt; go to CFG.
- CFG:
  - GBIF_cfg_val = 1, with GBIF_cfg_info = {id_q, rw_q} held stable.
  - On IFGB_cfg_rdy: if len_q == 0, go to DONE; otherwise go to RD when rw_q = 1, or WR when rw_q = 0.
- WR (pass-through, no buffering):
  - GBIF_wr_val = src_val.
  - src_rdy = IFGB_wr_rdy.
  - GBIF_wr_data = src_data.
  - A beat is src_val && IFGB_wr_rdy; each beat increments beat_cnt.
  - On the beat where beat_cnt == len_q-1, go to DONE.
- RD (pass-through, no buffering):
  - snk_val = IFGB_rd_val.
  - GBIF_rd_rdy = snk_rdy.
  - snk_data = IFGB_rd_data.
  - A beat is IFGB_rd_val && snk_rdy; counting and the last-beat rule are identical to WR.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- Strobes outside their state: GBIF_wr_val, src_rdy, snk_val and GBIF_rd_rdy are 0 outside WR/RD respectively. GBIF_cfg_val is 0 outside CFG.
- Pass-through data: GBIF_wr_data and snk_data follow their inputs combinationally and are don't-care while the matching valid is 0.
- beat_cnt holds its final value through DONE and IDLE until the next request is accepted.
- Width rules:
  - beat_cnt is LEN_WIDTH bits and never wraps, because the last-beat compare stops it at len_q.
  - The maximum transfer is 2^LEN_WIDTH−1 words.

## Timing
- Reset values: FSM = IDLE; req_rdy = 1; busy = 0; done = 0; beat_cnt = 0; GBIF_cfg_info = 0. All valid/ready outputs toward IF and GB are 0.
- Request latency: a request accepted in cycle t puts GBIF_cfg_val high in cycle t+1.
- Minimum write/read burst of N words with no stalls:
  - config handshake at t+1;
  - beats at t+2 … t+N+1;
  - done at t+N+2;
  - req_rdy back high at t+N+3.
- Config-only request (len = 0): done at t+2.
- Stalls: IFGB_cfg_rdy = 0 holds CFG with cfg_val and info stable. A low valid or ready on either side holds the beat with no count change.
- Request queuing: req_val asserted during busy is not accepted, and the request is held by the client. The first cycle that can accept is the cycle after done.
- Reset mid-transfer: state returns to IDLE on the next edge and the partial burst is abandoned. No done pulse is generated and beat_cnt = 0.
- Simultaneous events: no two handshakes can coincide, since only one is enabled per state.

## Test plan
- Reset: hold reset 3 cycles → req_rdy = 1, busy = 0, done = 0, beat_cnt = 0, all IF/GB valids 0.
- Write burst, no stalls: req rw=0, id=5, len=4 with src_val always high and IF ready → GBIF_cfg_info = 4'b1010 for exactly one cycle. Then 4 beats passed through unchanged, done at t+6, beat_cnt = 4.
- Read burst with backpressure: rw=1, id=2, len=3; snk_rdy toggles 1,0,1,0,1 and IFGB_rd_val is always high → cfg_info = 4'b0101. Exactly 3 words delivered, in order, and done occurs only after the 3rd beat.
- Config stall and len=0: rw=0, len=0 with IFGB_cfg_rdy low for 5 cycles → cfg_val stays high with info stable, done occurs 1 cycle after cfg_rdy rises, and no data strobes are ever asserted.
- Reset mid-burst: write len=8, assert reset after beat 3 → next cycle is IDLE, no done pulse, beat_cnt = 0. A subsequent len=2 write completes normally.
- Back-to-back: req_val held high with two requests (len=1 each) → the second is accepted only in the cycle after the first done, and there are exactly two done pulses.
